word_frame_parser: RTL and testbench

- Downstream consumer of the 4-to-16-bit asynchronous FIFO stage, running entirely in the dout_clk domain.
- Takes the 16-bit word stream (in_data/in_en) and hunts for a sync word, then reads a length word, payload words and a checksum word.
- Forwards payload with start/end markers and reports per-frame status plus saturating good/bad frame counters.
- Upstream has no backpressure, so the block never stalls its input.

---
 rtl/word_frame_parser_pkg.sv | 20 ++
 rtl/word_frame_parser_sat_counter.sv | 30 +++
 rtl/word_frame_parser.sv | 192 +++++++++++++++++++
 tb/tb_word_frame_parser.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/word_frame_parser_pkg.sv
// Shared definitions for the word frame parser.
// Holds the 2-bit parser state encoding, the error codes reported on
// err_code_o when a frame terminates, and the default sync word.
package word_frame_parser_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHECK   = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hA55A;

endpackage

// File: rtl/word_frame_parser_sat_counter.sv
// Saturating up-counter used for the good/bad frame statistics.
// Ports:
//   clk_i   - clock
//   rstn    - asynchronous active-low reset, clears the count
//   inc_i   - add one this cycle (ignored once the count is all-ones)
//   count_o - current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rstn,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  // Count up on each increment request and stick at all-ones so a long
  // run never wraps back to a misleadingly small value.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/word_frame_parser.sv
// Frame parser sitting behind the 4-to-16-bit async FIFO, dout_clk domain.
// Hunts for a sync word, reads a length word, forwards that many payload
// words with start/end markers, then compares a checksum word against the
// 16-bit running sum of the payload. Every frame termination (good, bad
// length, checksum error, timeout) produces a one-cycle frame_done_o pulse.
// The input is never stalled; the upstream FIFO has no backpressure.
// Ports:
//   dout_clk     - clock
//   rstn         - asynchronous active-low reset
//   in_data_i    - 16-bit word from the FIFO stage
//   in_en_i      - in_data_i valid this cycle
//   out_data_o   - payload word
//   out_valid_o  - out_data_o valid
//   out_sop_o    - first payload word of a frame
//   out_eop_o    - last payload word of a frame
//   frame_done_o - one-cycle pulse at frame termination
//   frame_ok_o   - qualifies frame_done_o, 1 = good frame
//   err_code_o   - error reason when frame_ok_o = 0 (see package)
//   good_cnt_o   - saturating count of good frames
//   bad_cnt_o    - saturating count of errored frames
module word_frame_parser
  import word_frame_parser_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int          MAX_LEN   = 64,
  parameter int          TIMEOUT   = 255,
  parameter int          CNT_W     = 16
) (
  input  logic             dout_clk,
  input  logic             rstn,
  input  logic [15:0]      in_data_i,
  input  logic             in_en_i,
  output logic [15:0]      out_data_o,
  output logic             out_valid_o,
  output logic             out_sop_o,
  output logic             out_eop_o,
  output logic             frame_done_o,
  output logic             frame_ok_o,
  output logic [1:0]       err_code_o,
  output logic [CNT_W-1:0] good_cnt_o,
  output logic [CNT_W-1:0] bad_cnt_o
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [15:0]         remaining_q, remaining_d;
  logic [15:0]         sum_q, sum_d;
  logic [IDLE_W-1:0]   idleCnt_q, idleCnt_d;
  logic                firstBeat_q, firstBeat_d;

  logic [15:0]         outData_q, outData_d;
  logic                outValid_q, outValid_d;
  logic                outSop_q, outSop_d;
  logic                outEop_q, outEop_d;
  logic                frameDone_q, frameDone_d;
  logic                frameOk_q, frameOk_d;
  logic [1:0]          errCode_q, errCode_d;

  // State and registered outputs. Everything the outside world sees comes
  // from these flops, one cycle after the word that caused it.
  always_ff @(posedge dout_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_HUNT;
      remaining_q <= '0;
      sum_q       <= '0;
      idleCnt_q   <= '0;
      firstBeat_q <= 1'b0;
      outData_q   <= '0;
      outValid_q  <= 1'b0;
      outSop_q    <= 1'b0;
      outEop_q    <= 1'b0;
      frameDone_q <= 1'b0;
      frameOk_q   <= 1'b0;
      errCode_q   <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      sum_q       <= sum_d;
      idleCnt_q   <= idleCnt_d;
      firstBeat_q <= firstBeat_d;
      outData_q   <= outData_d;
      outValid_q  <= outValid_d;
      outSop_q    <= outSop_d;
      outEop_q    <= outEop_d;
      frameDone_q <= frameDone_d;
      frameOk_q   <= frameOk_d;
      errCode_q   <= errCode_d;
    end
  end

  // Next-state logic. Inside a frame an idle cycle either bumps the idle
  // counter or, on the cycle the count would reach TIMEOUT, aborts the
  // frame. A word arriving on that same cycle wins and is consumed
  // normally. A sync value is only recognised while hunting, so the same
  // bit pattern inside a frame is ordinary data.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    sum_d       = sum_q;
    idleCnt_d   = idleCnt_q;
    firstBeat_d = firstBeat_q;
    outData_d   = outData_q;
    outValid_d  = 1'b0;
    outSop_d    = 1'b0;
    outEop_d    = 1'b0;
    frameDone_d = 1'b0;
    frameOk_d   = 1'b0;
    errCode_d   = ERR_NONE;

    if (state_q == ST_HUNT) begin
      idleCnt_d = '0;
      if (in_en_i && (in_data_i == SYNC_WORD)) begin
        state_d = ST_LEN;
      end
    end else if (!in_en_i) begin
      if (idleCnt_q == IDLE_W'(TIMEOUT - 1)) begin
        idleCnt_d   = '0;
        frameDone_d = 1'b1;
        errCode_d   = ERR_TMO;
        state_d     = ST_HUNT;
      end else begin
        idleCnt_d = idleCnt_q + IDLE_W'(1);
      end
    end else begin
      idleCnt_d = '0;
      case (state_q)
        ST_LEN: begin
          if ((in_data_i == 16'd0) || (in_data_i > 16'(MAX_LEN))) begin
            frameDone_d = 1'b1;
            errCode_d   = ERR_LEN;
            state_d     = ST_HUNT;
          end else begin
            remaining_d = in_data_i;
            sum_d       = '0;
            firstBeat_d = 1'b1;
            state_d     = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          outData_d   = in_data_i;
          outValid_d  = 1'b1;
          outSop_d    = firstBeat_q;
          firstBeat_d = 1'b0;
          sum_d       = sum_q + in_data_i;
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            outEop_d = 1'b1;
            state_d  = ST_CHECK;
          end
        end
        ST_CHECK: begin
          frameDone_d = 1'b1;
          if (in_data_i == sum_q) begin
            frameOk_d = 1'b1;
          end else begin
            errCode_d = ERR_CSUM;
          end
          state_d = ST_HUNT;
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end
  end

  // The counters are fed from the next-state termination pulse so their
  // new value becomes visible on the same cycle as frame_done_o.
  sat_counter #(.W(CNT_W)) u_good_cnt (
    .clk_i   (dout_clk),
    .rstn    (rstn),
    .inc_i   (frameDone_d & frameOk_d),
    .count_o (good_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_bad_cnt (
    .clk_i   (dout_clk),
    .rstn    (rstn),
    .inc_i   (frameDone_d & ~frameOk_d),
    .count_o (bad_cnt_o)
  );

  assign out_data_o   = outData_q;
  assign out_valid_o  = outValid_q;
  assign out_sop_o    = outSop_q;
  assign out_eop_o    = outEop_q;
  assign frame_done_o = frameDone_q;
  assign frame_ok_o   = frameOk_q;
  assign err_code_o   = errCode_q;

endmodule

// File: tb/tb_word_frame_parser.sv
// Directed bench for word_frame_parser. A narrow counter width is used so
// saturation can be reached with a handful of frames.
module tb_word_frame_parser;

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             dout_clk = 1'b0;
  logic             rstn = 1'b0;
  logic [15:0]      inData = '0;
  logic             inEn = 1'b0;
  logic [15:0]      outData;
  logic             outValid, outSop, outEop, frameDone, frameOk;
  logic [1:0]       errCode;
  logic [CNT_W-1:0] goodCnt, badCnt;

  int total = 0;
  int bad = 0;
  logic [CNT_W-1:0] expGood = '0;
  logic [CNT_W-1:0] expBad = '0;

  typedef struct {
    logic        en;
    logic [15:0] data;
    logic        v;
    logic        sop;
    logic        eop;
    logic        done;
    logic        ok;
    logic [1:0]  err;
    logic [15:0] odata;
  } vec_t;

  vec_t vecs[$];

  word_frame_parser #(
    .SYNC_WORD (16'hA55A),
    .MAX_LEN   (64),
    .TIMEOUT   (255),
    .CNT_W     (CNT_W)
  ) dut (
    .dout_clk     (dout_clk),
    .rstn         (rstn),
    .in_data_i    (inData),
    .in_en_i      (inEn),
    .out_data_o   (outData),
    .out_valid_o  (outValid),
    .out_sop_o    (outSop),
    .out_eop_o    (outEop),
    .frame_done_o (frameDone),
    .frame_ok_o   (frameOk),
    .err_code_o   (errCode),
    .good_cnt_o   (goodCnt),
    .bad_cnt_o    (badCnt)
  );

  // Free-running 10-unit clock.
  always #5 dout_clk = ~dout_clk;

  function automatic vec_t mk(input logic en, input logic [15:0] d,
                              input logic v, input logic sop, input logic eop,
                              input logic done, input logic ok,
                              input logic [1:0] err, input logic [15:0] od);
    vec_t r;
    r.en = en; r.data = d; r.v = v; r.sop = sop; r.eop = eop;
    r.done = done; r.ok = ok; r.err = err; r.odata = od;
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one input beat at the falling edge; return just after the
  // rising edge that registers it.
  task automatic applyStimulus(input logic en, input logic [15:0] d);
    @(negedge dout_clk);
    inEn = en;
    inData = d;
    @(posedge dout_clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    cmp({tag, " flags{v,sop,eop,done,ok,err}"},
        {25'd0, outValid, outSop, outEop, frameDone, frameOk, errCode},
        {25'd0, v.v, v.sop, v.eop, v.done, v.ok, v.err});
    if (v.v) cmp({tag, " out_data"}, {16'd0, outData}, {16'd0, v.odata});
    cmp({tag, " good_cnt"}, 32'(goodCnt), 32'(expGood));
    cmp({tag, " bad_cnt"}, 32'(badCnt), 32'(expBad));
  endtask

  task automatic runVec(input vec_t v, input string tag);
    applyStimulus(v.en, v.data);
    if (v.done && v.ok && expGood != CNT_MAX) expGood = expGood + 1'b1;
    if (v.done && !v.ok && expBad != CNT_MAX) expBad = expBad + 1'b1;
    checkOutput(v, tag);
  endtask

  task automatic sendOneWordFrame(input logic [15:0] d, input string tag);
    runVec(mk(1, 16'hA55A, 0, 0, 0, 0, 0, 0, 0), tag);
    runVec(mk(1, 16'h0001, 0, 0, 0, 0, 0, 0, 0), tag);
    runVec(mk(1, d, 1, 1, 1, 0, 0, 0, d), tag);
    runVec(mk(1, d, 0, 0, 0, 1, 1, 0, 0), tag);
  endtask

  task automatic checkAllZero(input string tag);
    cmp({tag, " all outputs"},
        {outData, outValid, outSop, outEop, frameDone, frameOk, errCode,
         goodCnt, badCnt},
        '0);
  endtask

  initial begin
    // Reset state
    #3;
    checkAllZero("reset");
    @(negedge dout_clk);
    @(negedge dout_clk);
    rstn = 1'b1;

    // Good frame with a mid-payload stall
    vecs.push_back(mk(1, 16'hA55A, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 16'h0003, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 16'h0001, 1, 1, 0, 0, 0, 0, 16'h0001));
    vecs.push_back(mk(1, 16'h0002, 1, 0, 0, 0, 0, 0, 16'h0002));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 16'h0003, 1, 0, 1, 0, 0, 0, 16'h0003));
    vecs.push_back(mk(1, 16'h0006, 0, 0, 0, 1, 1, 0, 0));
    // Checksum error: payload still forwarded
    vecs.push_back(mk(1, 16'hA55A, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 16'h0003, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 16'h0001, 1, 1, 0, 0, 0, 0, 16'h0001));
    vecs.push_back(mk(1, 16'h0002, 1, 0, 0, 0, 0, 0, 16'h0002));
    vecs.push_back(mk(1, 16'h0003, 1, 0, 1, 0, 0, 0, 16'h0003));
    vecs.push_back(mk(1, 16'h0007, 0, 0, 0, 1, 0, 2, 0));
    // Bad lengths 0 and MAX_LEN+1
    vecs.push_back(mk(1, 16'hA55A, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 16'hA55A, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 16'h0041, 0, 0, 0, 1, 0, 1, 0));
    // Garbage, then back-to-back frames; length-1 payload equals sync
    vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 16'hA55A, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 16'h0001, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 16'hA55A, 1, 1, 1, 0, 0, 0, 16'hA55A));
    vecs.push_back(mk(1, 16'hA55A, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 16'hA55A, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 16'h0002, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 16'h0010, 1, 1, 0, 0, 0, 0, 16'h0010));
    vecs.push_back(mk(1, 16'h0020, 1, 0, 1, 0, 0, 0, 16'h0020));
    vecs.push_back(mk(1, 16'h0030, 0, 0, 0, 1, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      runVec(vecs[i], $sformatf("vec%0d", i));
    end

    // Timeout after 255 idle cycles in PAYLOAD, no eop
    runVec(mk(1, 16'hA55A, 0, 0, 0, 0, 0, 0, 0), "tmo");
    runVec(mk(1, 16'h0002, 0, 0, 0, 0, 0, 0, 0), "tmo");
    runVec(mk(1, 16'h1234, 1, 1, 0, 0, 0, 0, 16'h1234), "tmo");
    for (int i = 0; i < 254; i++) begin
      runVec(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0), "tmo idle");
    end
    runVec(mk(0, 16'h0000, 0, 0, 0, 1, 0, 3, 0), "tmo expire");
    runVec(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0), "tmo after");

    // A word on the 255th idle cycle is consumed, no timeout
    runVec(mk(1, 16'hA55A, 0, 0, 0, 0, 0, 0, 0), "notmo");
    runVec(mk(1, 16'h0002, 0, 0, 0, 0, 0, 0, 0), "notmo");
    runVec(mk(1, 16'h1234, 1, 1, 0, 0, 0, 0, 16'h1234), "notmo");
    for (int i = 0; i < 254; i++) begin
      runVec(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0), "notmo idle");
    end
    runVec(mk(1, 16'h5678, 1, 0, 1, 0, 0, 0, 16'h5678), "notmo last");
    runVec(mk(1, 16'h68AC, 0, 0, 0, 1, 1, 0, 0), "notmo csum");

    // Saturation of good_cnt
    sendOneWordFrame(16'h0011, "sat1");
    sendOneWordFrame(16'h0022, "sat2");
    cmp("good_cnt max-1", 32'(goodCnt), 32'(CNT_MAX - 1'b1));
    sendOneWordFrame(16'h0033, "sat3");
    sendOneWordFrame(16'h0044, "sat4");
    cmp("good_cnt saturated", 32'(goodCnt), 32'(CNT_MAX));

    // Async reset in the middle of a payload
    runVec(mk(1, 16'hA55A, 0, 0, 0, 0, 0, 0, 0), "rst");
    runVec(mk(1, 16'h0003, 0, 0, 0, 0, 0, 0, 0), "rst");
    runVec(mk(1, 16'h0001, 1, 1, 0, 0, 0, 0, 16'h0001), "rst");
    inEn = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    checkAllZero("mid reset");
    expGood = '0;
    expBad = '0;
    @(negedge dout_clk);
    rstn = 1'b1;
    runVec(mk(1, 16'hA55A, 0, 0, 0, 0, 0, 0, 0), "post");
    runVec(mk(1, 16'h0003, 0, 0, 0, 0, 0, 0, 0), "post");
    runVec(mk(1, 16'h0001, 1, 1, 0, 0, 0, 0, 16'h0001), "post");
    runVec(mk(1, 16'h0002, 1, 0, 0, 0, 0, 0, 16'h0002), "post");
    runVec(mk(1, 16'h0003, 1, 0, 1, 0, 0, 0, 16'h0003), "post");
    runVec(mk(1, 16'h0006, 0, 0, 0, 1, 1, 0, 0), "post");
    cmp("post good_cnt", 32'(goodCnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
